// File: rtl/wb_stage_pkg.sv
// Shared pipeline constants: writeback source selects and load size/sign codes.
package wb_stage_pkg;

    // Writeback source select, as driven by the control unit.
    typedef enum logic [1:0] {
        WB_SEL_PC4  = 2'b00,
        WB_SEL_ALU  = 2'b01,
        WB_SEL_LOAD = 2'b10,
        WB_SEL_ZERO = 2'b11
    } wb_sel_e;

    // Load size/sign codes (funct3 encoding).
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } byte_num_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts and extends the addressed byte/halfword from a raw memory word.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  byte_num,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lane, then extend according to the load code.
    always_comb begin
        sel_byte = '0;
        sel_half = '0;
        data     = '0;
        case (offset)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = offset[1] ? word[31:16] : word[15:0];
        case (byte_num)
            LD_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            LD_LH:   data = {{16{sel_half[15]}}, sel_half};
            LD_LW:   data = word;
            LD_LBU:  data = {24'h0, sel_byte};
            LD_LHU:  data = {16'h0, sel_half};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result select and retire counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_insn_vld,
    input  logic [4:0]           i_rd_addr,
    input  logic                 i_rd_wren,
    input  logic [1:0]           i_wb_sel,
    input  logic [2:0]           i_byte_num,
    input  logic [31:0]          i_alu_data,
    input  logic [31:0]          i_ld_data,
    input  logic [31:0]          i_pc_four,
    output logic [4:0]           o_rd_addr,
    output logic [31:0]          o_rd_data,
    output logic                 o_rd_wren,
    output logic                 o_insn_vld,
    output logic [INSTRET_W-1:0] o_instret
);

    logic                 vld_q;
    logic                 wr_pend_q;
    logic                 rd_wren_q;
    logic [4:0]           rd_addr_q;
    logic [1:0]           wb_sel_q;
    logic [2:0]           byte_num_q;
    logic [31:0]          alu_q;
    logic [31:0]          ld_q;
    logic [31:0]          pc4_q;
    logic [INSTRET_W-1:0] instret_q;
    logic [31:0]          ld_aligned;

    // MEM/WB register and retire counter; reset > flush > stall > load.
    // wr_pend_q lets the regfile write fire on the edge the entry first leaves
    // WB, then blocks repeats while the entry is held, keeping o_rd_wren a
    // pure register output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q      <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_wren_q  <= 1'b0;
            rd_addr_q  <= '0;
            wb_sel_q   <= '0;
            byte_num_q <= '0;
            alu_q      <= '0;
            ld_q       <= '0;
            pc4_q      <= '0;
            instret_q  <= '0;
        end else if (i_flush) begin
            vld_q     <= 1'b0;
            wr_pend_q <= 1'b0;
        end else if (i_stall) begin
            wr_pend_q <= 1'b0;
        end else begin
            vld_q      <= i_insn_vld;
            wr_pend_q  <= 1'b1;
            rd_wren_q  <= i_rd_wren;
            rd_addr_q  <= i_rd_addr;
            wb_sel_q   <= i_wb_sel;
            byte_num_q <= i_byte_num;
            alu_q      <= i_alu_data;
            ld_q       <= i_ld_data;
            pc4_q      <= i_pc_four;
            if (i_insn_vld) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    load_align u_load_align (
        .word     (ld_q),
        .offset   (alu_q[1:0]),
        .byte_num (byte_num_q),
        .data     (ld_aligned)
    );

    // Writeback data select from the stored source code.
    always_comb begin
        o_rd_data = '0;
        case (wb_sel_q)
            WB_SEL_PC4:  o_rd_data = pc4_q;
            WB_SEL_ALU:  o_rd_data = alu_q;
            WB_SEL_LOAD: o_rd_data = ld_aligned;
            default:     o_rd_data = '0;
        endcase
    end

    assign o_rd_wren  = vld_q & rd_wren_q & (rd_addr_q != 5'd0) & wr_pend_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_insn_vld = vld_q;
    assign o_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage with a 4-bit retire counter.
module tb_wb_stage;

    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          reset, stall, flush, insn_vld, rd_wren;
    logic [4:0]    rd_addr;
    logic [1:0]    wb_sel;
    logic [2:0]    byte_num;
    logic [31:0]   alu_data, ld_data, pc_four;
    logic [4:0]    o_rd_addr;
    logic [31:0]   o_rd_data;
    logic          o_rd_wren, o_insn_vld;
    logic [IW-1:0] o_instret;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]    addr;
        logic [31:0]   data;
        logic          wren;
        logic          vld;
        logic [IW-1:0] cnt;
        logic          data_care;
    } exp_t;
    exp_t sb[$];

    // Independent reference state.
    logic          m_vld, m_wrok, m_care;
    logic [4:0]    m_addr;
    logic [31:0]   m_data;
    logic [IW-1:0] m_cnt;

    always #5 clk = ~clk;

    wb_stage #(.INSTRET_W(IW)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_insn_vld (insn_vld),
        .i_rd_addr  (rd_addr),
        .i_rd_wren  (rd_wren),
        .i_wb_sel   (wb_sel),
        .i_byte_num (byte_num),
        .i_alu_data (alu_data),
        .i_ld_data  (ld_data),
        .i_pc_four  (pc_four),
        .o_rd_addr  (o_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_wren  (o_rd_wren),
        .o_insn_vld (o_insn_vld),
        .o_instret  (o_instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] bn);
        logic [31:0] sh_b, sh_h;
        sh_b = w >> (8 * int'(off));
        sh_h = w >> (16 * int'(off[1]));
        case (bn)
            3'b000:  return 32'($signed(sh_b[7:0]));
            3'b001:  return 32'($signed(sh_h[15:0]));
            3'b010:  return w;
            3'b100:  return {24'h0, sh_b[7:0]};
            3'b101:  return {16'h0, sh_h[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic cycle(input logic rst, input logic stl, input logic fl, input logic v,
                         input logic [4:0] rd, input logic we, input logic [1:0] sel,
                         input logic [2:0] bn, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc);
        exp_t e;
        exp_t g;
        reset = rst; stall = stl; flush = fl; insn_vld = v; rd_addr = rd; rd_wren = we;
        wb_sel = sel; byte_num = bn; alu_data = alu; ld_data = ld; pc_four = pc;
        if (rst) begin
            m_vld = 0; m_wrok = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_care = 1;
        end else if (fl) begin
            m_vld = 0; m_wrok = 0; m_care = 0;
        end else if (stl) begin
            m_wrok = 0;
        end else begin
            m_vld  = v;
            m_wrok = v && we && (rd != 5'd0);
            m_addr = rd;
            m_care = 1;
            case (sel)
                2'b00:   m_data = pc;
                2'b01:   m_data = alu;
                2'b10:   m_data = ref_load(ld, alu[1:0], bn);
                default: m_data = 32'h0;
            endcase
            if (v) m_cnt = m_cnt + 1'b1;
        end
        e.addr = m_addr; e.data = m_data; e.wren = m_wrok; e.vld = m_vld;
        e.cnt = m_cnt; e.data_care = m_care;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            check("wren", 32'(o_rd_wren), 32'(g.wren));
            check("vld", 32'(o_insn_vld), 32'(g.vld));
            check("instret", 32'(o_instret), 32'(g.cnt));
            if (g.data_care) begin
                check("addr", 32'(o_rd_addr), 32'(g.addr));
                check("data", o_rd_data, g.data);
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 5'd0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [IW-1:0] cnt_before;
        m_vld = 0; m_wrok = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_care = 0;
        @(posedge clk);
        #1;
        // Reset state
        cycle(1, 0, 0, 1, 5'd7, 1, 2'b01, 3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h55);
        check("rst_data", o_rd_data, 32'h0);
        check("rst_addr", 32'(o_rd_addr), 32'h0);

        // LB, offset 3
        cycle(0, 0, 0, 1, 5'd5, 1, 2'b10, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        check("lb_const", o_rd_data, 32'hFFFF_FF80);
        check("lb_wren", 32'(o_rd_wren), 32'h1);
        // LHU / LH, offset 2
        cycle(0, 0, 0, 1, 5'd6, 1, 2'b10, 3'b101, 32'h0000_0002, 32'h80FF_7F01, 32'h0);
        check("lhu_const", o_rd_data, 32'h0000_80FF);
        cycle(0, 0, 0, 1, 5'd6, 1, 2'b10, 3'b001, 32'h0000_0002, 32'h80FF_7F01, 32'h0);
        check("lh_const", o_rd_data, 32'hFFFF_80FF);
        // Remaining load codes and offsets
        cycle(0, 0, 0, 1, 5'd8, 1, 2'b10, 3'b001, 32'h0000_0003, 32'h80FF_7F01, 32'h0);
        cycle(0, 0, 0, 1, 5'd8, 1, 2'b10, 3'b101, 32'h0000_0001, 32'h80FF_7F01, 32'h0);
        cycle(0, 0, 0, 1, 5'd9, 1, 2'b10, 3'b010, 32'h0000_0003, 32'h80FF_7F01, 32'h0);
        check("lw_const", o_rd_data, 32'h80FF_7F01);
        cycle(0, 0, 0, 1, 5'd9, 1, 2'b10, 3'b100, 32'h0000_0003, 32'h80FF_7F01, 32'h0);
        cycle(0, 0, 0, 1, 5'd9, 1, 2'b10, 3'b000, 32'h0000_0001, 32'h80FF_7F01, 32'h0);
        cycle(0, 0, 0, 1, 5'd9, 1, 2'b10, 3'b011, 32'h0000_0000, 32'h80FF_7F01, 32'h0);
        cycle(0, 0, 0, 1, 5'd9, 1, 2'b10, 3'b110, 32'h0000_0000, 32'h80FF_7F01, 32'h0);
        cycle(0, 0, 0, 1, 5'd10, 1, 2'b01, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0);
        cycle(0, 0, 0, 1, 5'd11, 1, 2'b11, 3'b010, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h44);
        check("zero_sel", o_rd_data, 32'h0);
        cycle(0, 0, 0, 1, 5'd12, 0, 2'b01, 3'b000, 32'h1111_2222, 32'h0, 32'h0);

        // Write to x0 is suppressed but still retires
        cnt_before = o_instret;
        cycle(0, 0, 0, 1, 5'd0, 1, 2'b01, 3'b000, 32'h0000_0042, 32'h0, 32'h0);
        check("x0_wren", 32'(o_rd_wren), 32'h0);
        check("x0_cnt", 32'(o_instret), 32'(cnt_before + 1'b1));

        // JAL then a 3-cycle stall
        cnt_before = o_instret;
        cycle(0, 0, 0, 1, 5'd1, 1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_0104);
        check("jal_wren", 32'(o_rd_wren), 32'h1);
        for (int unsigned k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 1, 5'd3, 1, 2'b01, 3'b000, 32'h9999_0000 + k, 32'h0, 32'h0);
            check("jal_hold_data", o_rd_data, 32'h0000_0104);
            check("jal_hold_wren", 32'(o_rd_wren), 32'h0);
        end
        check("jal_cnt", 32'(o_instret), 32'(cnt_before + 1'b1));
        idle();

        // Flush with stall and valid input
        cycle(0, 0, 0, 1, 5'd4, 1, 2'b01, 3'b000, 32'h7, 32'h0, 32'h0);
        cnt_before = o_instret;
        cycle(0, 1, 1, 1, 5'd4, 1, 2'b01, 3'b000, 32'h8, 32'h0, 32'h0);
        check("fs_vld", 32'(o_insn_vld), 32'h0);
        check("fs_cnt", 32'(o_instret), 32'(cnt_before));
        cycle(0, 0, 1, 1, 5'd4, 1, 2'b01, 3'b000, 32'h9, 32'h0, 32'h0);

        // Counter wrap: 17 retirements after reset, then reset over a pending write
        cycle(1, 0, 0, 0, 5'd0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        for (int unsigned k = 0; k < 17; k++) begin
            cycle(0, 0, 0, 1, 5'(k + 1), 1, 2'b01, 3'b000, 32'(k), 32'h0, 32'(4 * k));
        end
        check("wrap_cnt", 32'(o_instret), 32'h1);
        check("wrap_pending", 32'(o_rd_wren), 32'h1);
        cycle(1, 0, 0, 1, 5'd2, 1, 2'b01, 3'b000, 32'h5, 32'h0, 32'h0);
        check("rst_pend_wren", 32'(o_rd_wren), 32'h0);
        check("rst_pend_cnt", 32'(o_instret), 32'h0);

        // Random mix
        for (int unsigned k = 0; k < 60; k++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom), 1'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
